frame_stream_source: RTL and testbench

Frame-buffer reader that regenerates an 8-bit pixel stream with `fvh`/`dv` framing and feeds the video filter chain (blur, threshold, peak detect). It owns the raster counters, issues sequential reads to a fixed-latency frame memory and aligns the returned data with its framing. It is the producer end of the same `fvh`/`dv`/pixel interface the filters consume.

---
 rtl/video_pkg.sv | 17 +
 rtl/video_delay_line.sv | 30 +++
 rtl/frame_stream_source.sv | 164 ++++++++++++++++
 tb/tb_frame_stream_source.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video source/filter chain: fvh bit indices,
// source FSM states and the idle framing value.
package video_pkg;

    localparam int unsigned FVH_F = 2;
    localparam int unsigned FVH_V = 1;
    localparam int unsigned FVH_H = 0;

    localparam logic [2:0] FVH_IDLE = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } src_state_t;

endpackage

// File: rtl/video_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous active-low clear to CLR_VAL.
module video_delay_line #(
    parameter int unsigned       WIDTH   = 5,
    parameter int unsigned       DEPTH   = 2,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= CLR_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/frame_stream_source.sv
// Frame-buffer reader producing an fvh/dv/pixel stream from a fixed-latency memory.
// Optional FRAME_SRC_TEST_PATTERN_EN adds pattern_sel for an hcnt^vcnt test pattern.
module frame_stream_source
    import video_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned H_BLANK    = 138,
    parameter int unsigned V_BLANK    = 45,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
`ifdef FRAME_SRC_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [2:0]        fvh_out,
    output logic              dv_out,
    output logic [7:0]        px_out,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned H_TOTAL = IMG_WIDTH + H_BLANK;
    localparam int unsigned V_TOTAL = IMG_HEIGHT + V_BLANK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = $clog2(RD_LATENCY + 1);

`ifdef FRAME_SRC_TEST_PATTERN_EN
    localparam int unsigned DL_W = 14;
`else
    localparam int unsigned DL_W = 5;
`endif
    localparam logic [DL_W-1:0] DL_CLR = DL_W'({FVH_IDLE, 2'b00});

    src_state_t        state, next_state;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [DW-1:0]     drain_cnt;
    logic [ADDR_W-1:0] ptr;
    logic              field;
    logic              started;

    logic h_end, v_end, frame_end, frame_start, drain_end;
    logic hblank, vblank, active, sel;
    logic [4:0]      raster_flags;
    logic [DL_W-1:0] dl_in, dl_out;

    assign hblank      = (hcnt >= HW'(IMG_WIDTH));
    assign vblank      = (vcnt >= VW'(IMG_HEIGHT));
    assign h_end       = (hcnt == HW'(H_TOTAL - 1));
    assign v_end       = (vcnt == VW'(V_TOTAL - 1));
    assign frame_end   = (state == RUN) && h_end && v_end;
    assign frame_start = en && ((state == IDLE) || frame_end);
    assign drain_end   = (drain_cnt == DW'(RD_LATENCY));
    assign active      = (state == RUN) && !hblank && !vblank;

`ifdef FRAME_SRC_TEST_PATTERN_EN
    assign sel = pattern_sel;
`else
    assign sel = 1'b0;
`endif

    assign rd_en   = active && !sel;
    assign rd_addr = ptr;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = RUN;
            RUN:     if (frame_end && !en) next_state = DRAIN;
            DRAIN:   if (drain_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt      <= '0;
            vcnt      <= '0;
            drain_cnt <= '0;
            ptr       <= '0;
            field     <= 1'b0;
            started   <= 1'b0;
        end else begin
            if (state == RUN && !frame_end) begin
                if (h_end) begin
                    hcnt <= '0;
                    vcnt <= vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end else begin
                hcnt <= '0;
                vcnt <= '0;
            end

            // pointer tracks active cycles, not reads, so pattern mode keeps it in step
            if (state != RUN || frame_end) ptr <= '0;
            else if (active)               ptr <= ptr + ADDR_W'(1);

            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                drain_cnt <= '0;

            if (frame_start) begin
                started <= 1'b1;
                if (started) field <= ~field;
            end
        end
    end

    assign raster_flags = (state == RUN) ? {field, vblank, hblank, active, frame_end}
                                         : {field, FVH_IDLE[FVH_V], FVH_IDLE[FVH_H], 2'b00};

`ifdef FRAME_SRC_TEST_PATTERN_EN
    assign dl_in = {sel, 8'(hcnt) ^ 8'(vcnt), raster_flags};
`else
    assign dl_in = raster_flags;
`endif

    video_delay_line #(
        .WIDTH   (DL_W),
        .DEPTH   (RD_LATENCY),
        .CLR_VAL (DL_CLR)
    ) u_delay (
        .clk   (clk),
        .rst_n (reset),
        .d     (dl_in),
        .q     (dl_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fvh_out    <= FVH_IDLE;
            dv_out     <= 1'b0;
            px_out     <= '0;
            frame_done <= 1'b0;
        end else begin
            fvh_out    <= dl_out[4:2];
            dv_out     <= dl_out[1];
            frame_done <= dl_out[0];
`ifdef FRAME_SRC_TEST_PATTERN_EN
            if (!dl_out[1])      px_out <= '0;
            else if (dl_out[13]) px_out <= dl_out[12:5];
            else                 px_out <= rd_data;
`else
            px_out <= dl_out[1] ? rd_data : '0;
`endif
        end
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Randomised bench for frame_stream_source with a raster-level reference model,
// a per-cycle compare process and hand-computed directed checks.
module tb_frame_stream_source;

    localparam int W = 8, H = 4, HB = 4, VB = 2, L = 2, AW = 6;
    localparam int LINE  = W + HB;
    localparam int FRAME = LINE * (H + VB);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          pattern_sel = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [2:0]    fvh_out;
    logic          dv_out;
    logic [7:0]    px_out;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_stream_source #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .H_BLANK    (HB),
        .V_BLANK    (VB),
        .RD_LATENCY (L),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
`ifdef FRAME_SRC_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fvh_out    (fvh_out),
        .dv_out     (dv_out),
        .px_out     (px_out),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // memory: data = address[7:0], L clocks after the read cycle
    logic [7:0] mem_pipe [L];
    always @(posedge clk) begin
        mem_pipe[0] <= 8'(rd_addr);
        for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rd_data = mem_pipe[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0] fvh;
        logic       dv;
        logic [7:0] px;
        logic       last;
    } tup_t;

    tup_t q[$];
    int   m_state = 0;   // 0 idle, 1 running, 2 draining
    int   m_pos = 0;     // clock index within the frame
    int   m_drain = 0;
    logic m_field = 1'b0;
    logic m_started = 1'b0;
    logic model_ok = 1'b0;

    function automatic tup_t raster_tuple();
        tup_t t;
        int h, v;
        bit act;
        h = m_pos % LINE;
        v = m_pos / LINE;
        act = (h < W) && (v < H);
        if (m_state == 1) begin
            t.fvh  = {m_field, v >= H, h >= W};
            t.dv   = act;
            t.px   = !act ? 8'h00 : (pattern_sel ? 8'(h ^ v) : 8'(v * W + h));
            t.last = (m_pos == FRAME - 1);
        end else begin
            t = '{fvh: {m_field, 2'b11}, dv: 1'b0, px: 8'h00, last: 1'b0};
        end
        return t;
    endfunction

    function automatic int exp_addr();
        int h, v;
        h = m_pos % LINE;
        v = m_pos / LINE;
        if (m_state != 1) return 0;
        if (v >= H) return W * H;
        return v * W + ((h < W) ? h : W);
    endfunction

    task automatic start_frame();
        if (m_started) m_field = ~m_field;
        m_started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_state = 0; m_pos = 0; m_drain = 0;
            m_field = 1'b0; m_started = 1'b0;
            q.delete();
            repeat (L + 1) q.push_back('{fvh: 3'b011, dv: 1'b0, px: 8'h00, last: 1'b0});
            model_ok = 1'b1;
        end else begin
            q.push_back(raster_tuple());
            void'(q.pop_front());
            case (m_state)
                0: if (en) begin m_state = 1; m_pos = 0; start_frame(); end
                1: if (m_pos == FRAME - 1) begin
                       if (en) begin m_pos = 0; start_frame(); end
                       else begin m_state = 2; m_drain = 0; end
                   end else m_pos++;
                default: if (m_drain == L) m_state = 0; else m_drain++;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            tup_t e;
            bit   exp_rd;
            e = q[0];
            exp_rd = (m_state == 1) && (m_pos % LINE < W) && (m_pos / LINE < H) && !pattern_sel;
            check("fvh_out", 32'(fvh_out), 32'(e.fvh));
            check("dv_out", 32'(dv_out), 32'(e.dv));
            check("px_out", 32'(px_out), 32'(e.px));
            check("frame_done", 32'(frame_done), 32'(e.last));
            check("busy", 32'(busy), 32'(m_state != 0));
            check("rd_en", 32'(rd_en), 32'(exp_rd));
            check("rd_addr", 32'(rd_addr), 32'(exp_addr()));
        end
    end

    // ---------------- stimulus and directed checks ----------------
    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("idle_fvh", 32'(fvh_out), 32'h3);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_rd_en", 32'(rd_en), 32'h0);
            #1;
        end

        en = 1'b1;
        for (int n = 0; n < 222; n++) begin
            @(negedge clk);
            case (n)
                0:   begin check("first_rd_en", 32'(rd_en), 1); check("first_addr", 32'(rd_addr), 0); end
                3:   begin check("first_dv", 32'(dv_out), 1); check("first_px", 32'(px_out), 0);
                           check("first_fvh", 32'(fvh_out), 32'h0); end
                10:  check("px7", 32'(px_out), 7);
                11:  begin check("hblank_dv", 32'(dv_out), 0); check("hblank_h", 32'(fvh_out[0]), 1); end
                30:  check("px_h3_v2", 32'(px_out), 32'h13);
                73:  check("fd_before", 32'(frame_done), 0);
                74:  check("fd_frame1", 32'(frame_done), 1);
                75:  begin check("field_f2", 32'(fvh_out[2]), 1); check("f2_dv", 32'(dv_out), 1); end
                146: check("fd_frame2", 32'(frame_done), 1);
                147: check("field_f3", 32'(fvh_out[2]), 0);
                218: begin check("fd_frame3", 32'(frame_done), 1); check("drain_busy", 32'(busy), 1); end
                219: begin check("busy_off", 32'(busy), 0); check("no_rd_after", 32'(rd_en), 0); end
                default: ;
            endcase
            #1;
            if (n == 2 * FRAME + 2 * LINE) en = 1'b0;
        end

        // reset in the middle of pixel 5, line 1
        en = 1'b1;
        for (int n = 0; n <= 17; n++) begin
            @(negedge clk);
            if (n == 17) check("pre_reset_addr", 32'(rd_addr), 13);
            #1;
        end
        reset = 1'b0;
        #1;
        check("rst_fvh", 32'(fvh_out), 32'h3);
        check("rst_dv", 32'(dv_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_addr", 32'(rd_addr), 0);
        @(negedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) check("restart_addr", 32'(rd_addr), 0);
            if (n == 3) begin check("restart_fvh", 32'(fvh_out), 0); check("restart_px", 32'(px_out), 0); end
            #1;
        end

`ifdef FRAME_SRC_TEST_PATTERN_EN
        reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1; pattern_sel = 1'b1;
        for (int n = 0; n < 31; n++) begin
            @(negedge clk);
            if (n == 0)  check("pat_rd_en", 32'(rd_en), 0);
            if (n == 30) check("pat_px", 32'(px_out), 32'h01);
            #1;
        end
`endif

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 2999) == 0) reset = 1'b0;
            if ($urandom_range(0, 59) == 0) en = ~en;
`ifdef FRAME_SRC_TEST_PATTERN_EN
            if ($urandom_range(0, 99) == 0) pattern_sel = ~pattern_sel;
`endif
        end

        reset = 1'b1;
        en = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
